// File: rtl/uart_tx_param_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param_if
// Description : Request/handshake bundle between the TX FIFO and uart_tx_param.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_param_if #(
    parameter int DBIT_MAX = 9
);
    logic [DBIT_MAX-1:0] din;
    logic [3:0]          cfg_dbit;
    logic [1:0]          cfg_parity;
    logic [1:0]          cfg_stop;
    logic                tx_valid;
    logic                tx_ready;
    logic                tx_busy;
    logic                tx_done_tick;

    modport master (
        output din, cfg_dbit, cfg_parity, cfg_stop, tx_valid,
        input  tx_ready, tx_busy, tx_done_tick
    );

    modport slave (
        input  din, cfg_dbit, cfg_parity, cfg_stop, tx_valid,
        output tx_ready, tx_busy, tx_done_tick
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : UART transmitter, runtime 5-9 data bits, N/E/O parity,
//               1/1.5/2 stop bits, ready/valid request handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
    parameter int DBIT_MAX = 9,
    parameter int OVS      = 16
) (
    input  wire                   clk,
    input  wire                   reset,
    input  wire                   s_tick,
    uart_tx_param_if.slave        tx_if,
    output logic                  tx
);
    localparam int c_CW = $clog2(2 * OVS);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [c_CW-1:0] c_BIT_LAST   = c_CW'(OVS - 1);
    localparam logic [c_CW-1:0] c_STOP15_LAST = c_CW'((3 * OVS) / 2 - 1);
    localparam logic [c_CW-1:0] c_STOP2_LAST = c_CW'(2 * OVS - 1);

    logic [2:0]          r_state;
    logic [c_CW-1:0]     r_s_cnt;
    logic [3:0]          r_n;
    logic [3:0]          r_len;
    logic [DBIT_MAX-1:0] r_shift;
    logic                r_par_en;
    logic                r_par_bit;
    logic [1:0]          r_stop;
    logic                r_done;
    logic                r_tx;

    logic [3:0]          w_dbit;
    logic [DBIT_MAX-1:0] w_used;
    logic                w_par_en;
    logic                w_par_bit;
    logic [c_CW-1:0]     w_stop_last;

    // Clamp requested length into the supported 5..DBIT_MAX window
    always_comb begin
        w_dbit = tx_if.cfg_dbit;
        if (tx_if.cfg_dbit < 4'd5)
            w_dbit = 4'd5;
        else if (tx_if.cfg_dbit > 4'(DBIT_MAX))
            w_dbit = 4'(DBIT_MAX);
    end

    always_comb begin
        w_used = '0;
        for (int i = 0; i < DBIT_MAX; i++)
            w_used[i] = tx_if.din[i] & (i < int'(w_dbit));
    end

    assign w_par_en  = (tx_if.cfg_parity == 2'b01) || (tx_if.cfg_parity == 2'b10);
    assign w_par_bit = (tx_if.cfg_parity == 2'b10) ? ~(^w_used) : (^w_used);

    always_comb begin
        case (r_stop)
            2'b00:   w_stop_last = c_BIT_LAST;
            2'b01:   w_stop_last = c_STOP15_LAST;
            default: w_stop_last = c_STOP2_LAST;
        endcase
    end

    // tx is loaded with the line value of the next state on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_s_cnt   <= '0;
            r_n       <= '0;
            r_len     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop    <= '0;
            r_done    <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (tx_if.tx_valid) begin
                        r_state   <= c_START;
                        r_s_cnt   <= '0;
                        r_n       <= '0;
                        r_shift   <= tx_if.din;
                        r_len     <= w_dbit;
                        r_par_en  <= w_par_en;
                        r_par_bit <= w_par_bit;
                        r_stop    <= tx_if.cfg_stop;
                        r_tx      <= 1'b0;
                    end
                end
                c_START: begin
                    if (s_tick) begin
                        if (r_s_cnt == c_BIT_LAST) begin
                            r_state <= c_DATA;
                            r_s_cnt <= '0;
                            r_n     <= '0;
                            r_tx    <= r_shift[0];
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                c_DATA: begin
                    if (s_tick) begin
                        if (r_s_cnt == c_BIT_LAST) begin
                            r_s_cnt <= '0;
                            r_shift <= r_shift >> 1;
                            r_n     <= r_n + 4'd1;
                            if (r_n == r_len - 4'd1) begin
                                if (r_par_en) begin
                                    r_state <= c_PARITY;
                                    r_tx    <= r_par_bit;
                                end else begin
                                    r_state <= c_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_tx <= r_shift[1];
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                c_PARITY: begin
                    if (s_tick) begin
                        if (r_s_cnt == c_BIT_LAST) begin
                            r_state <= c_STOP;
                            r_s_cnt <= '0;
                            r_tx    <= 1'b1;
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                c_STOP: begin
                    if (s_tick) begin
                        if (r_s_cnt == w_stop_last) begin
                            r_state <= c_IDLE;
                            r_s_cnt <= '0;
                            r_done  <= 1'b1;
                            r_tx    <= 1'b1;
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_s_cnt <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx                 = r_tx;
    assign tx_if.tx_ready     = (r_state == c_IDLE);
    assign tx_if.tx_busy      = (r_state != c_IDLE);
    assign tx_if.tx_done_tick = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Directed self-checking bench for uart_tx_param (OVS=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;
    localparam int c_DBIT_MAX = 9;
    localparam int c_OVS      = 16;

    logic clk;
    logic rst;
    logic s_tick;
    logic tx;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_param_if #(.DBIT_MAX(c_DBIT_MAX)) u_if ();

    uart_tx_param #(
        .DBIT_MAX(c_DBIT_MAX),
        .OVS     (c_OVS)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .s_tick(s_tick),
        .tx_if (u_if.slave),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present a request and step past its accept edge; ends #1 after that edge
    task automatic start_frame(input logic [8:0] din, input logic [3:0] dbit,
                               input logic [1:0] par, input logic [1:0] stop,
                               input bit hold);
        @(posedge clk); #1;
        u_if.din        = din;
        u_if.cfg_dbit   = dbit;
        u_if.cfg_parity = par;
        u_if.cfg_stop   = stop;
        u_if.tx_valid   = 1'b1;
        check("ready_pre", 32'(u_if.tx_ready), 32'd1);
        @(posedge clk); #1;
        if (!hold) u_if.tx_valid = 1'b0;
        u_if.cfg_dbit   = 4'd0;
        u_if.cfg_parity = 2'b11;
        u_if.cfg_stop   = 2'b00;
        u_if.din        = '0;
        check("start_tx", 32'(tx), 32'd0);
        check("start_busy", 32'(u_if.tx_busy), 32'd1);
    endtask

    // exp_bits: data (+parity) LSB first, nb slots; total_t: expected done cycle
    task automatic run_body(input logic [15:0] exp_bits, input int nb, input int total_t,
                            input int pulse_at, input logic exp_tx_after);
        int  done_c = -1;
        for (int c = 1; c <= total_t + 20; c++) begin
            @(posedge clk); #1;
            if (pulse_at != 0 && c == pulse_at + 1) u_if.tx_valid = 1'b0;
            if (pulse_at != 0 && c == pulse_at) begin
                u_if.tx_valid = 1'b1;
                check("ready_busy", 32'(u_if.tx_ready), 32'd0);
            end
            if (u_if.tx_done_tick) begin
                done_c = c;
                break;
            end
            if ((c % 16) == 8 && (c / 16) <= nb + 1) begin
                if (c / 16 == 0)
                    check("bit_start", 32'(tx), 32'd0);
                else if (c / 16 <= nb)
                    check("bit_data", 32'(tx), 32'(exp_bits[c/16 - 1]));
                else
                    check("bit_stop", 32'(tx), 32'd1);
            end
        end
        check("done_cycle", 32'(done_c), 32'(total_t));
        if (done_c > 0) begin
            check("done_ready", 32'(u_if.tx_ready), 32'd1);
            check("done_tx", 32'(tx), 32'd1);
            @(posedge clk); #1;
            check("done_width", 32'(u_if.tx_done_tick), 32'd0);
            check("after_tx", 32'(tx), 32'(exp_tx_after));
            check("after_busy", 32'(u_if.tx_busy), 32'(!exp_tx_after));
        end
    endtask

    initial begin
        bit saw_done;
        rst             = 1'b1;
        s_tick          = 1'b1;
        u_if.din        = '0;
        u_if.cfg_dbit   = 4'd8;
        u_if.cfg_parity = 2'b00;
        u_if.cfg_stop   = 2'b00;
        u_if.tx_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(u_if.tx_ready), 32'd1);
        check("rst_busy", 32'(u_if.tx_busy), 32'd0);
        check("rst_done", 32'(u_if.tx_done_tick), 32'd0);
        rst = 1'b0;

        // 8N1 0xA5
        start_frame(9'h0A5, 4'd8, 2'b00, 2'b00, 1'b0);
        run_body(16'h00A5, 8, 160, 0, 1'b1);

        // 7E1 0x41: two ones -> parity 0; 7O1 -> parity 1
        start_frame(9'h041, 4'd7, 2'b01, 2'b00, 1'b0);
        run_body(16'h0041, 8, 160, 0, 1'b1);
        start_frame(9'h041, 4'd7, 2'b10, 2'b00, 1'b0);
        run_body(16'h00C1, 8, 160, 0, 1'b1);

        // 5O2 0x1E3: low bits 00011, odd parity 1, 16*7+32
        start_frame(9'h1E3, 4'd5, 2'b10, 2'b10, 1'b0);
        run_body(16'h0023, 6, 144, 0, 1'b1);

        // cfg_dbit below range clamps to 5 (same frame, 2 stop via 11)
        start_frame(9'h1E3, 4'd2, 2'b10, 2'b11, 1'b0);
        run_body(16'h0023, 6, 144, 0, 1'b1);

        // 9N1.5 0x1FF: 16*10+24; cfg_dbit=12 clamps to 9
        start_frame(9'h1FF, 4'd9, 2'b00, 2'b01, 1'b0);
        run_body(16'h01FF, 9, 184, 0, 1'b1);
        start_frame(9'h1FF, 4'd12, 2'b11, 2'b01, 1'b0);
        run_body(16'h01FF, 9, 184, 0, 1'b1);

        // Back-to-back: second frame accepted on the done-pulse cycle
        start_frame(9'h000, 4'd8, 2'b00, 2'b00, 1'b1);
        u_if.cfg_dbit = 4'd8;
        run_body(16'h0000, 8, 160, 0, 1'b0);
        u_if.tx_valid = 1'b0;
        run_body(16'h0000, 8, 160, 0, 1'b1);

        // Mid-frame request pulse is dropped
        start_frame(9'h0F0, 4'd8, 2'b00, 2'b00, 1'b0);
        run_body(16'h00F0, 8, 160, 50, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("no_queue_busy", 32'(u_if.tx_busy), 32'd0);

        // Reset during DATA bit 3
        start_frame(9'h0FF, 4'd8, 2'b00, 2'b00, 1'b0);
        repeat (72) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(u_if.tx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(u_if.tx_busy), 32'd0);
        check("mid_rst_done", 32'(u_if.tx_done_tick), 32'd0);
        saw_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (u_if.tx_done_tick) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        start_frame(9'h000, 4'd8, 2'b00, 2'b00, 1'b0);
        run_body(16'h0000, 8, 160, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
